iomem_arbiter: RTL

IOMEM_ARBITER -- requirements
Module: iomem_arbiter

---
 rtl/iomem_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/iomem_arbiter.sv
// iomem_arbiter: routes CPU peripheral requests to one of four address-paged
// slaves, with a per-request ready timeout and sticky bus-error reporting.
module iomem_arbiter #(
  parameter logic [7:0]  BASE0   = 8'h03,
  parameter logic [7:0]  BASE1   = 8'h04,
  parameter logic [7:0]  BASE2   = 8'h05,
  parameter logic [7:0]  BASE3   = 8'h06,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk_bufg,
  input  logic          resetn,
  input  logic          iomem_valid,
  input  logic [31:0]   iomem_addr,
  input  logic [3:0]    iomem_wstrb,
  output logic          iomem_ready,
  output logic [31:0]   iomem_rdata,
  output logic [3:0]    slv_valid,
  input  logic [3:0]    slv_ready,
  input  logic [127:0]  slv_rdata,
  input  logic          err_clr,
  output logic          err_irq,
  output logic [31:0]   err_addr,
  output logic [7:0]    err_count
);

  localparam int unsigned NS = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned TW = 8;
  localparam int unsigned CW = 8;
  localparam logic [DW-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [NS-1:0] sel_q, sel_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [NS-1:0] hit_sel;
  logic [DW-1:0] sel_rdata;
  logic          err_event;
  logic          err_irq_d;
  logic [CW-1:0] err_count_d;
  logic [AW-1:0] err_addr_d;
  logic          wstrb_unused;

  // Byte strobes do not affect routing; slaves see the CPU bus directly.
  assign wstrb_unused = ^iomem_wstrb;

  // Request qualifier: registered select gated by the live CPU valid.
  assign slv_valid = (state_q == WAIT && iomem_valid) ? sel_q : '0;

  // Page decode with fixed priority slave 0 > 1 > 2 > 3.
  always_comb begin
    hit_sel = '0;
    if      (addr_q[31:24] == BASE0) hit_sel = 4'b0001;
    else if (addr_q[31:24] == BASE1) hit_sel = 4'b0010;
    else if (addr_q[31:24] == BASE2) hit_sel = 4'b0100;
    else if (addr_q[31:24] == BASE3) hit_sel = 4'b1000;
  end

  // Read-data slice of the selected slave.
  always_comb begin
    sel_rdata = '0;
    for (int unsigned n = 0; n < NS; n++) begin
      if (sel_q[n]) sel_rdata = sel_rdata | slv_rdata[n*DW +: DW];
    end
  end

  // Next-state, datapath and error bookkeeping.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    sel_d       = sel_q;
    timer_d     = timer_q;
    rdata_d     = rdata_q;
    err_event   = 1'b0;
    err_irq_d   = err_irq;
    err_count_d = err_count;
    err_addr_d  = err_addr;

    case (state_q)
      IDLE: begin
        if (iomem_valid) begin
          addr_d  = iomem_addr;
          state_d = DECODE;
        end
      end
      DECODE: begin
        sel_d = hit_sel;
        if (|hit_sel) begin
          timer_d = '0;
          state_d = WAIT;
        end else begin
          rdata_d   = '0;
          err_event = 1'b1;
          state_d   = RESP;
        end
      end
      WAIT: begin
        if (!iomem_valid) begin
          sel_d   = '0;
          state_d = IDLE;
        end else if (|(slv_ready & sel_q)) begin
          rdata_d = sel_rdata;
          state_d = RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          rdata_d   = TIMEOUT_DATA;
          err_event = 1'b1;
          state_d   = RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RESP: begin
        sel_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A clear colliding with a new error still records that error.
    if (err_event) begin
      err_irq_d   = 1'b1;
      err_addr_d  = addr_q;
      if (err_clr)                    err_count_d = CW'(1);
      else if (err_count != '1)       err_count_d = err_count + CW'(1);
    end else if (err_clr) begin
      err_irq_d   = 1'b0;
      err_count_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_bufg) begin
    if (!resetn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      sel_q       <= '0;
      timer_q     <= '0;
      rdata_q     <= '0;
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      err_irq     <= 1'b0;
      err_addr    <= '0;
      err_count   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      sel_q       <= sel_d;
      timer_q     <= timer_d;
      rdata_q     <= rdata_d;
      iomem_ready <= (state_d == RESP);
      iomem_rdata <= (state_d == RESP) ? rdata_d : '0;
      err_irq     <= err_irq_d;
      err_addr    <= err_addr_d;
      err_count   <= err_count_d;
    end
  end

endmodule
